// File: rtl/snake_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | snake_pkg: direction codes, FSM encodings and helpers shared by    |
// | the snake direction controller.               Revision: 1.0       |
// +-------------------------------------------------------------------+
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;
  localparam dir_t DIR_RESET = DIR_RIGHT;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Opposite pairs share the axis bit (bit1) and differ in the sense bit.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dir_fifo2.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | dir_fifo2: 2-deep FIFO of pending directions with head/tail view.  |
// |                                               Revision: 1.0       |
// +-------------------------------------------------------------------+
module dir_fifo2
  import snake_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  dir_t       data_i,
  output dir_t       head_o,
  output dir_t       tail_o,
  output logic [1:0] count_o
);

  dir_t       e0_q, e0_d;
  dir_t       e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_pop;
  logic       do_push;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i && (cnt_q != 2'd0);
    // A full FIFO still accepts a push when the same cycle frees a slot.
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    if (clear_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = data_i;
          else               e1_d = data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = data_i;
          end else begin
            e0_d = e1_q;
            e1_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e0_q  <= DIR_RESET;
      e1_q  <= DIR_RESET;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = e0_q;
  assign tail_o  = (cnt_q == 2'd2) ? e1_q : e0_q;
  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/snake_dir_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | snake_dir_ctrl: button presses to committed heading + step tick.   |
// |                                               Revision: 1.0       |
// +-------------------------------------------------------------------+
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned STEP_DIV = 25_000_000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_button_u,
  input  logic       I_button_d,
  input  logic       I_button_r,
  input  logic       I_button_l,
  input  logic       I_game_over,
  output logic [1:0] O_dir,
  output logic       O_step,
  output logic       O_running
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [3:0]       btn_now;
  logic [3:0]       btn_q;
  logic [3:0]       press;
  logic             press_vld;
  dir_t             press_dir;
  dir_t             last_dir;
  logic             accept;
  logic             tick;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t             dir_q, dir_d;
  logic             step_q, step_d;

  logic             fifo_clear, fifo_push, fifo_pop;
  dir_t             fifo_head, fifo_tail;
  logic [1:0]       fifo_cnt;

  assign btn_now = {I_button_u, I_button_d, I_button_r, I_button_l};
  assign press   = btn_now & ~btn_q;

  always_comb begin
    press_vld = 1'b1;
    press_dir = DIR_UP;
    if      (press[3]) press_dir = DIR_UP;
    else if (press[2]) press_dir = DIR_DOWN;
    else if (press[1]) press_dir = DIR_RIGHT;
    else if (press[0]) press_dir = DIR_LEFT;
    else               press_vld = 1'b0;
  end

  // A new turn is judged against the latest pending turn, not the current heading.
  assign last_dir = (fifo_cnt != 2'd0) ? fifo_tail : dir_q;
  assign accept   = press_vld && (press_dir != last_dir) && !is_opposite(press_dir, last_dir);
  assign tick     = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (press_vld)   state_d = ST_RUN;
      ST_RUN:  if (I_game_over) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = '0;
    dir_d      = dir_q;
    step_d     = 1'b0;
    fifo_clear = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_vld) begin
          dir_d      = press_dir;
          fifo_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (I_game_over) begin
          dir_d      = DIR_RESET;
          fifo_clear = 1'b1;
        end else begin
          cnt_d     = tick ? '0 : cnt_q + 1'b1;
          step_d    = tick;
          fifo_pop  = tick;
          fifo_push = accept;
          if (tick && (fifo_cnt != 2'd0)) dir_d = fifo_head;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      btn_q  <= 4'b0000;
      cnt_q  <= '0;
      dir_q  <= DIR_RESET;
      step_q <= 1'b0;
    end else begin
      btn_q  <= btn_now;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  dir_fifo2 u_fifo (
    .clk_i   (I_clk),
    .rst_ni  (I_rst_n),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (press_dir),
    .head_o  (fifo_head),
    .tail_o  (fifo_tail),
    .count_o (fifo_cnt)
  );

  assign O_dir     = dir_q;
  assign O_step    = step_q;
  assign O_running = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_snake_dir_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_snake_dir_ctrl: directed + random checks against a queue model. |
// |                                               Revision: 1.0       |
// +-------------------------------------------------------------------+
module tb_snake_dir_ctrl;

  localparam int STEP_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bu = 1'b0, bd = 1'b0, br = 1'b0, bl = 1'b0, go = 1'b0;
  logic [1:0] dir;
  logic       step, running;

  snake_dir_ctrl #(.STEP_DIV(STEP_DIV), .CNT_W(3)) dut (
    .I_clk       (clk),
    .I_rst_n     (rst_n),
    .I_button_u  (bu),
    .I_button_d  (bd),
    .I_button_r  (br),
    .I_button_l  (bl),
    .I_game_over (go),
    .O_dir       (dir),
    .O_step      (step),
    .O_running   (running)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // Reference model: heading, run flag, cycles since entering RUN, pending turns.
  logic [1:0] m_dir;
  logic       m_run;
  logic       m_step;
  int         m_cycles;
  logic [1:0] m_q[$];
  logic [3:0] m_prev;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dir = 2'b11; m_run = 1'b0; m_step = 1'b0; m_cycles = 0;
    m_q.delete(); m_prev = 4'b0000;
  endtask

  task automatic model_edge();
    logic [3:0] now, pr;
    logic       pv, ok;
    logic [1:0] pd, last;
    now = {bu, bd, br, bl};
    pr  = now & ~m_prev;
    pv  = (pr != 4'b0000);
    pd  = pr[3] ? 2'b00 : pr[2] ? 2'b01 : pr[1] ? 2'b11 : 2'b10;
    m_prev = now;
    m_step = 1'b0;
    if (!m_run) begin
      if (pv) begin
        m_dir = pd; m_run = 1'b1; m_cycles = 0; m_q.delete();
      end
    end else if (go) begin
      m_run = 1'b0; m_dir = 2'b11; m_cycles = 0; m_q.delete();
    end else begin
      last = (m_q.size() != 0) ? m_q[$] : m_dir;
      ok = pv && (pd != last) && !((pd[1] == last[1]) && (pd[0] != last[0]));
      m_cycles++;
      if (m_cycles % STEP_DIV == 0) begin
        m_step = 1'b1;
        if (m_q.size() != 0) m_dir = m_q.pop_front();
      end
      if (ok && m_q.size() < 2) m_q.push_back(pd);
    end
  endtask

  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      chk("dir", dir, m_dir);
      chk("step", {1'b0, step}, {1'b0, m_step});
      chk("running", {1'b0, running}, {1'b0, m_run});
    end
  endtask

  task automatic btn(input logic [3:0] b);
    {bu, bd, br, bl} = b;
  endtask

  task automatic wait_step();
    for (int i = 0; i < 2 * STEP_DIV; i++) begin
      cycle();
      if (step) break;
    end
    chk("wait_step", {1'b0, step}, 2'b01);
  endtask

  int steps_seen;
  int changes;
  logic [1:0] prev_dir;

  initial begin
    model_reset();
    #12;
    chk("reset_dir", dir, 2'b11);
    chk("reset_step", {1'b0, step}, 2'b00);
    chk("reset_running", {1'b0, running}, 2'b00);
    rst_n = 1'b1;
    cycle(3);

    // IDLE start and tick cadence
    btn(4'b1000); cycle();
    chk("t1_dir", dir, 2'b00);
    chk("t1_running", {1'b0, running}, 2'b01);
    btn(4'b0000);
    steps_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (step) steps_seen++;
    end
    chk_int("t1_steps", steps_seen, 3);

    // Reach heading right, then two buffered turns
    btn(4'b0010); cycle(); btn(4'b0000); cycle(8);
    chk("t2_pre", dir, 2'b11);
    wait_step();
    btn(4'b1000); cycle(); btn(4'b0000); cycle();
    btn(4'b0001); cycle(); btn(4'b0000); cycle();
    chk("t2_first", dir, 2'b00);
    chk("t2_first_step", {1'b0, step}, 2'b01);
    cycle(4);
    chk("t2_second", dir, 2'b10);

    // Reversal rejection and held-button single press
    btn(4'b1000); cycle(); btn(4'b0000); cycle();
    btn(4'b0010); cycle(); btn(4'b0000); cycle(8);
    chk("t3_pre", dir, 2'b11);
    btn(4'b0001); cycle(); btn(4'b0000); cycle(8);
    chk("t3_reject", dir, 2'b11);
    btn(4'b1000);
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      prev_dir = dir;
      cycle();
      if (dir !== prev_dir) changes++;
    end
    btn(4'b0000);
    chk("t3_held", dir, 2'b00);
    chk_int("t3_changes", changes, 1);

    // Simultaneous presses and full-queue drop
    btn(4'b0001); cycle(); btn(4'b0000); cycle(8);
    chk("t4_pre", dir, 2'b10);
    wait_step();
    btn(4'b1010); cycle(); btn(4'b0000); cycle(3);
    chk("t4_prio", dir, 2'b00);
    cycle(4);
    chk("t4_prio_only", dir, 2'b00);
    wait_step();
    btn(4'b0010); cycle(); btn(4'b1000); cycle(); btn(4'b0010); cycle();
    btn(4'b0000); cycle();
    chk("t4_pop1", dir, 2'b11);
    cycle(4);
    chk("t4_pop2", dir, 2'b00);
    cycle(4);
    chk("t4_dropped", dir, 2'b00);

    // Push coincident with pop
    wait_step();
    btn(4'b0010); cycle(); btn(4'b0000); cycle(2);
    btn(4'b0100); cycle();
    chk("t5_pop", dir, 2'b11);
    btn(4'b0000); cycle(4);
    chk("t5_push", dir, 2'b01);
    cycle(4);
    chk("t5_empty", dir, 2'b01);

    // Game over on a tick, then async reset mid-run
    wait_step();
    cycle(3);
    go = 1'b1; cycle(); go = 1'b0;
    chk("t6_nostep", {1'b0, step}, 2'b00);
    chk("t6_dir", dir, 2'b11);
    chk("t6_running", {1'b0, running}, 2'b00);
    btn(4'b1000); cycle(); btn(4'b0000); cycle(6);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_dir", dir, 2'b11);
    chk("t6_rst_step", {1'b0, step}, 2'b00);
    chk("t6_rst_running", {1'b0, running}, 2'b00);
    model_reset();
    #3 rst_n = 1'b1;

    // Randomized level activity
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) bu = ~bu;
      if ($urandom_range(0, 5) == 0) bd = ~bd;
      if ($urandom_range(0, 5) == 0) br = ~br;
      if ($urandom_range(0, 5) == 0) bl = ~bl;
      go = ($urandom_range(0, 39) == 0);
      cycle();
    end
    go = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
